// File: rtl/shcnt_pkg.sv
// ----------------------------------------------------------------------------
// shcnt_pkg
// Shared definitions for the shared-counter arbiter: counter op encoding,
// arbiter state enum and burst counter width.
// ----------------------------------------------------------------------------
package shcnt_pkg;

    // Counter operation encoding, shared by both requesters
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    // Burst counter is wide enough for BURST_MAX up to 15
    localparam int unsigned BURST_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN_A = 2'b01,
        ST_OWN_B = 2'b10
    } state_e;

endpackage

// File: rtl/shared_cnt_arbiter_if.sv
// ----------------------------------------------------------------------------
// shared_cnt_arbiter_if
// Request/op bus from the two requesters plus grant/counter status back.
//   req_a/op_a/data_a, req_b/op_b/data_b : requester side (master drives)
//   gnt_a/gnt_b/cnt/cnt_wrap              : arbiter side (slave drives)
//   grants_a/grants_b                     : only when SHCNT_STATS_EN is defined
// Modports: master (requesters / bench), slave (arbiter).
// ----------------------------------------------------------------------------
interface shared_cnt_arbiter_if #(
    parameter int unsigned CNT_W = 8
);
    logic             req_a;
    logic [1:0]       op_a;
    logic [CNT_W-1:0] data_a;
    logic             req_b;
    logic [1:0]       op_b;
    logic [CNT_W-1:0] data_b;
    logic             gnt_a;
    logic             gnt_b;
    logic [CNT_W-1:0] cnt;
    logic             cnt_wrap;
`ifdef SHCNT_STATS_EN
    logic [7:0]       grants_a;
    logic [7:0]       grants_b;

    modport master (
        output req_a, op_a, data_a, req_b, op_b, data_b,
        input  gnt_a, gnt_b, cnt, cnt_wrap, grants_a, grants_b
    );
    modport slave (
        input  req_a, op_a, data_a, req_b, op_b, data_b,
        output gnt_a, gnt_b, cnt, cnt_wrap, grants_a, grants_b
    );
`else
    modport master (
        output req_a, op_a, data_a, req_b, op_b, data_b,
        input  gnt_a, gnt_b, cnt, cnt_wrap
    );
    modport slave (
        input  req_a, op_a, data_a, req_b, op_b, data_b,
        output gnt_a, gnt_b, cnt, cnt_wrap
    );
`endif
endinterface

// File: rtl/shcnt_datapath.sv
// ----------------------------------------------------------------------------
// shcnt_datapath
// Counter register with op decode and wrap detection.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : apply i_op this edge (owner granted)
//   i_op, i_data   : selected op and load value
//   o_cnt          : registered counter value
//   o_wrap         : one-cycle pulse after INC max->0 or DEC 0->max
// ----------------------------------------------------------------------------
module shcnt_datapath
    import shcnt_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_op,
    input  logic [CNT_W-1:0] i_data,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);

    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_wrap, w_wrap_d;

    always_comb begin
        w_cnt_d  = r_cnt;
        w_wrap_d = 1'b0;
        if (i_en) begin
            case (i_op)
                OP_INC: begin
                    w_cnt_d  = r_cnt + CNT_W'(1);
                    w_wrap_d = &r_cnt;
                end
                OP_DEC: begin
                    w_cnt_d  = r_cnt - CNT_W'(1);
                    w_wrap_d = ~|r_cnt;
                end
                OP_LOAD: w_cnt_d = i_data;
                default: w_cnt_d = r_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_d;
            r_wrap <= w_wrap_d;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/shared_cnt_arbiter.sv
// ----------------------------------------------------------------------------
// shared_cnt_arbiter
// Round-robin arbiter for two requesters sharing one counter, with burst
// limiting so a continuously requesting owner yields after BURST_MAX cycles
// when the other side is waiting.
//   clk, rst_n : clock, async active-low reset
//   bus        : shared_cnt_arbiter_if.slave (requests/ops in, grants/cnt out)
// Optional: define SHCNT_STATS_EN to add saturating grant counters
// grants_a/grants_b on the bus.
// ----------------------------------------------------------------------------
module shared_cnt_arbiter
    import shcnt_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_cnt_arbiter_if.slave   bus
);

    localparam logic [BURST_W-1:0] BurstLast = BURST_W'(BURST_MAX - 1);

    state_e               r_state, w_state_d;
    logic                 r_last_b, w_last_b_d;   // last owner was B
    logic [BURST_W-1:0]   r_burst, w_burst_d;
    logic                 w_en;
    logic [1:0]           w_op;
    logic [CNT_W-1:0]     w_data;

    always_comb begin
        w_state_d  = r_state;
        w_last_b_d = r_last_b;
        w_burst_d  = r_burst;
        case (r_state)
            ST_IDLE: begin
                w_burst_d = '0;
                // Tie goes to the side that did not own last
                if (bus.req_a && (!bus.req_b || r_last_b)) begin
                    w_state_d = ST_OWN_A;
                end else if (bus.req_b) begin
                    w_state_d = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (!bus.req_a || (r_burst == BurstLast && bus.req_b)) begin
                    w_state_d  = bus.req_b ? ST_OWN_B : ST_IDLE;
                    w_last_b_d = 1'b0;
                    w_burst_d  = '0;
                end else if (r_burst == BurstLast) begin
                    w_burst_d = '0;  // nobody waiting: restart the burst
                end else begin
                    w_burst_d = r_burst + BURST_W'(1);
                end
            end
            ST_OWN_B: begin
                if (!bus.req_b || (r_burst == BurstLast && bus.req_a)) begin
                    w_state_d  = bus.req_a ? ST_OWN_A : ST_IDLE;
                    w_last_b_d = 1'b1;
                    w_burst_d  = '0;
                end else if (r_burst == BurstLast) begin
                    w_burst_d = '0;
                end else begin
                    w_burst_d = r_burst + BURST_W'(1);
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_last_b <= 1'b1;
            r_burst  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_last_b <= w_last_b_d;
            r_burst  <= w_burst_d;
        end
    end

    assign bus.gnt_a = (r_state == ST_OWN_A);
    assign bus.gnt_b = (r_state == ST_OWN_B);

    // Only the current owner's op reaches the counter
    assign w_en   = (r_state == ST_OWN_A) || (r_state == ST_OWN_B);
    assign w_op   = (r_state == ST_OWN_A) ? bus.op_a : bus.op_b;
    assign w_data = (r_state == ST_OWN_A) ? bus.data_a : bus.data_b;

    shcnt_datapath #(
        .CNT_W (CNT_W)
    ) u_datapath (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_en    (w_en),
        .i_op    (w_op),
        .i_data  (w_data),
        .o_cnt   (bus.cnt),
        .o_wrap  (bus.cnt_wrap)
    );

`ifdef SHCNT_STATS_EN
    logic [7:0] r_grants_a, r_grants_b;
    logic       w_enter_a, w_enter_b;

    assign w_enter_a = (w_state_d == ST_OWN_A) && (r_state != ST_OWN_A);
    assign w_enter_b = (w_state_d == ST_OWN_B) && (r_state != ST_OWN_B);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grants_a <= '0;
            r_grants_b <= '0;
        end else begin
            if (w_enter_a && r_grants_a != 8'hFF) r_grants_a <= r_grants_a + 8'd1;
            if (w_enter_b && r_grants_b != 8'hFF) r_grants_b <= r_grants_b + 8'd1;
        end
    end

    assign bus.grants_a = r_grants_a;
    assign bus.grants_b = r_grants_b;
`endif

endmodule
